fejkon_pcie_tx_arbiter: RTL

//  Shares the single 256-bit PCIe TX Avalon-ST stream (tx_st_*) between N packet sources
//  (completion path, DMA data path, ...). Arbitration is round-robin at packet granularity:
//  a grant is held from sop to eop. One registered output stage. Protocol errors are drained and counted.

---
 rtl/fejkon_pcie_tx_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/fejkon_pcie_tx_arbiter.sv
// fejkon_pcie_tx_arbiter: round-robin, packet-granular arbiter sharing one PCIe TX Avalon-ST stream among N_SRC sources
// Ports: clk/reset (async, active high); in_* per-source Avalon-ST sinks packed source i at [i*W +: W], in_ready back;
//        tx_st_* registered Avalon-ST source (ready latency 0); grant_src/busy show the packet owner;
//        proto_err_cnt saturating count of out-of-packet beats dropped in IDLE.
module fejkon_pcie_tx_arbiter #(
  parameter int N_SRC   = 3,
  parameter int DATA_W  = 256,
  parameter int EMPTY_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC*DATA_W-1:0]  in_data,
  input  logic [N_SRC*EMPTY_W-1:0] in_empty,
  input  logic [N_SRC-1:0]         in_sop,
  input  logic [N_SRC-1:0]         in_eop,
  input  logic [N_SRC-1:0]         in_error,
  input  logic [N_SRC-1:0]         in_valid,
  output logic [N_SRC-1:0]         in_ready,
  output logic [DATA_W-1:0]        tx_st_data,
  output logic [EMPTY_W-1:0]       tx_st_empty,
  output logic                     tx_st_startofpacket,
  output logic                     tx_st_endofpacket,
  output logic                     tx_st_error,
  output logic                     tx_st_valid,
  input  logic                     tx_st_ready,
  output logic [2:0]               grant_src,
  output logic                     busy,
  output logic [CNT_W-1:0]         proto_err_cnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PKT  = 1'b1;
  logic [0:0]       r_state;
  logic [2:0]       r_last;
  logic [2:0]       r_grant;
  logic [CNT_W-1:0] r_err_cnt;
  logic [N_SRC-1:0] w_cand, w_perr;
  logic [2:0]       w_win, w_sel;
  logic             w_found, w_can, w_load, w_idle;
  assign w_idle = r_state == IDLE;
  assign w_can  = !tx_st_valid || tx_st_ready;
  assign w_cand = in_valid & in_sop;
  assign w_perr = in_valid & ~in_sop;
  // circular search starting just after the last packet owner
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= N_SRC; k++)
      if (!w_found && w_cand[(int'(r_last) + k) % N_SRC]) begin
        w_found = 1'b1;
        w_win   = 3'((int'(r_last) + k) % N_SRC);
      end
  end
  assign w_sel  = w_idle ? w_win : r_grant;
  assign w_load = w_can && (w_idle ? w_found : in_valid[w_sel]);
  // out-of-packet beats are drained (ready=1) only while idle
  assign in_ready = reset ? '0 :
                    w_idle ? (w_perr | (N_SRC'(w_found && w_can) << w_win)) :
                    (N_SRC'(w_can) << r_grant);
  assign grant_src     = r_grant;
  assign busy          = r_state == PKT;
  assign proto_err_cnt = r_err_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state             <= IDLE;
      r_last              <= 3'(N_SRC - 1);
      r_grant             <= '0;
      r_err_cnt           <= '0;
      tx_st_data          <= '0;
      tx_st_empty         <= '0;
      tx_st_startofpacket <= 1'b0;
      tx_st_endofpacket   <= 1'b0;
      tx_st_error         <= 1'b0;
      tx_st_valid         <= 1'b0;
    end else begin
      if (w_load) begin
        tx_st_data          <= in_data[w_sel*DATA_W +: DATA_W];
        tx_st_empty         <= in_empty[w_sel*EMPTY_W +: EMPTY_W];
        tx_st_startofpacket <= in_sop[w_sel];
        tx_st_endofpacket   <= in_eop[w_sel];
        tx_st_error         <= in_error[w_sel];
        tx_st_valid         <= 1'b1;
      end else if (tx_st_ready) tx_st_valid <= 1'b0;
      if (w_load && in_eop[w_sel]) begin
        r_state <= IDLE;
        r_last  <= w_sel;
      end else if (w_load && w_idle) begin
        r_state <= PKT;
        r_grant <= w_win;
      end
      if (w_idle && |w_perr && r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end
endmodule
